// File: rtl/steer_pkg.sv
// Shared types and helpers for the quadrature steering encoder.
// Phase order for positive/right motion is PH0 -> PH1 -> PH2 -> PH3 -> PH0.
package steer_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   localparam logic [1:0] PH0 = 2'b00;
   localparam logic [1:0] PH1 = 2'b01;
   localparam logic [1:0] PH2 = 2'b11;
   localparam logic [1:0] PH3 = 2'b10;

   // dir=1 walks the sequence forward (right/positive), dir=0 walks it backward.
   function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
      logic [1:0] nxt;
      case (phase)
         PH0:     nxt = dir ? PH1 : PH3;
         PH1:     nxt = dir ? PH2 : PH0;
         PH2:     nxt = dir ? PH3 : PH1;
         default: nxt = dir ? PH0 : PH2;
      endcase
      return nxt;
   endfunction

   // Magnitude of a signed byte; -128 saturates to 127 so it fits in 7 bits.
   function automatic logic [6:0] abs_sat8(input logic [7:0] axis);
      logic [6:0] mag;
      if (!axis[7]) mag = axis[6:0];
      else if (axis == 8'h80) mag = 7'd127;
      else mag = 7'(~axis + 8'd1);
      return mag;
   endfunction

endpackage

// File: rtl/steer_quad_chan.sv
// One steering channel: request decode, IDLE/RUN FSM, step-period counter
// and quadrature phase register.
module steer_quad_chan
   import steer_pkg::*;
#(
   parameter int PERIOD_W    = 16,
   parameter int CLKDIV_SLOW = 22500,
   parameter int CLKDIV_FAST = 5625,
   parameter int ACCEL_DEC   = 2250,
   parameter int STEP_K      = 132,
   parameter int DEADZONE    = 16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       ce_i,
   input  logic       mode_i,
   input  logic       left_i,
   input  logic       right_i,
   input  logic [7:0] axis_i,
   output logic [1:0] steer_o,
   output logic       active_o,
   output logic       step_o
);

   localparam logic [PERIOD_W-1:0] SLOW_W  = PERIOD_W'(CLKDIV_SLOW);
   localparam logic [PERIOD_W-1:0] FAST_W  = PERIOD_W'(CLKDIV_FAST);
   localparam logic [PERIOD_W-1:0] DEC_W   = PERIOD_W'(ACCEL_DEC);
   localparam logic [PERIOD_W-1:0] K_W     = PERIOD_W'(STEP_K);
   localparam logic [PERIOD_W-1:0] ONE_W   = PERIOD_W'(1);
   localparam logic [PERIOD_W:0]   FLOOR_W = (PERIOD_W+1)'(CLKDIV_FAST + ACCEL_DEC);
   localparam logic [7:0]          DZ_W    = 8'((DEADZONE > 255) ? 255 : DEADZONE);

   state_e              state_q, state_d;
   logic                dir_q, dir_d;
   logic                modeLat_q, modeLat_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] count_q, count_d;
   logic [1:0]          phase_q, phase_d;
   logic                step_q, step_d;

   logic                req;
   logic                reqDir;
   logic [6:0]          mag;
   logic [PERIOD_W-1:0] analogPeriod;
   logic [PERIOD_W-1:0] entryPeriod;
   logic [PERIOD_W-1:0] rampPeriod;

   // Request decode and the candidate periods for an entry or a post-step reload.
   always_comb begin
      mag          = abs_sat8(axis_i);
      analogPeriod = FAST_W + PERIOD_W'(7'd127 - mag) * K_W;
      if (mode_i) begin
         req    = ({1'b0, mag} >= DZ_W);
         reqDir = !axis_i[7] && (axis_i != 8'd0);
      end else begin
         req    = left_i ^ right_i;
         reqDir = right_i;
      end
      entryPeriod = mode_i ? analogPeriod : SLOW_W;
      if (mode_i) rampPeriod = analogPeriod;
      else if ({1'b0, period_q} >= FLOOR_W) rampPeriod = period_q - DEC_W;
      else rampPeriod = FAST_W;
   end

   // A direction or mode change while running restarts the interval as if from IDLE.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      modeLat_d = modeLat_q;
      period_d  = period_q;
      count_d   = count_q;
      phase_d   = phase_q;
      step_d    = 1'b0;
      if (ce_i) begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  state_d   = RUN;
                  dir_d     = reqDir;
                  modeLat_d = mode_i;
                  period_d  = entryPeriod;
                  count_d   = entryPeriod - ONE_W;
               end
            end
            default: begin
               if (!req) begin
                  state_d = IDLE;
               end else if ((reqDir != dir_q) || (mode_i != modeLat_q)) begin
                  dir_d     = reqDir;
                  modeLat_d = mode_i;
                  period_d  = entryPeriod;
                  count_d   = entryPeriod - ONE_W;
               end else if (count_q != '0) begin
                  count_d = count_q - ONE_W;
               end else begin
                  phase_d  = next_phase(phase_q, dir_q);
                  step_d   = 1'b1;
                  period_d = rampPeriod;
                  count_d  = rampPeriod - ONE_W;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         dir_q     <= 1'b0;
         modeLat_q <= 1'b0;
         period_q  <= SLOW_W;
         count_q   <= '0;
         phase_q   <= PH0;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         modeLat_q <= modeLat_d;
         period_q  <= period_d;
         count_q   <= count_d;
         phase_q   <= phase_d;
         step_q    <= step_d;
      end
   end

   assign steer_o  = phase_q;
   assign active_o = (state_q == RUN);
   assign step_o   = step_q;

endmodule

// File: rtl/steer_quad_multi.sv
// Multi-channel joystick/analog-to-quadrature steering encoder; one
// independent steer_quad_chan per channel with packed buses.
module steer_quad_multi
   import steer_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int PERIOD_W    = 16,
   parameter int CLKDIV_SLOW = 22500,
   parameter int CLKDIV_FAST = 5625,
   parameter int ACCEL_DEC   = 2250,
   parameter int STEP_K      = 132,
   parameter int DEADZONE    = 16
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  ce,
   input  logic [CHANNELS-1:0]   mode,
   input  logic [CHANNELS-1:0]   left,
   input  logic [CHANNELS-1:0]   right,
   input  logic [8*CHANNELS-1:0] axis,
   output logic [2*CHANNELS-1:0] steer,
   output logic [CHANNELS-1:0]   active,
   output logic [CHANNELS-1:0]   step
);

   // Every period must fit the counter, and a zero period would never step.
   if (longint'(CLKDIV_FAST) + 127 * longint'(STEP_K) >= (longint'(1) << PERIOD_W)) begin : g_chkAnalog
      $error("steer_quad_multi: analog period range exceeds PERIOD_W");
   end
   if (longint'(CLKDIV_SLOW) >= (longint'(1) << PERIOD_W)) begin : g_chkSlow
      $error("steer_quad_multi: CLKDIV_SLOW exceeds PERIOD_W");
   end
   if (CLKDIV_FAST < 1) begin : g_chkFast
      $error("steer_quad_multi: CLKDIV_FAST must be at least 1");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      steer_quad_chan #(
         .PERIOD_W   (PERIOD_W),
         .CLKDIV_SLOW(CLKDIV_SLOW),
         .CLKDIV_FAST(CLKDIV_FAST),
         .ACCEL_DEC  (ACCEL_DEC),
         .STEP_K     (STEP_K),
         .DEADZONE   (DEADZONE)
      ) u_chan (
         .clk_i   (CLK),
         .reset_i (reset),
         .ce_i    (ce),
         .mode_i  (mode[i]),
         .left_i  (left[i]),
         .right_i (right[i]),
         .axis_i  (axis[8*i +: 8]),
         .steer_o (steer[2*i +: 2]),
         .active_o(active[i]),
         .step_o  (step[i])
      );
   end

endmodule

// File: tb/tb_steer_quad_multi.sv
// Bench for steer_quad_multi: directed vector table, ce-gating/reset sequences
// and randomized traffic, all checked against a tick-level behavioural model.
module tb_steer_quad_multi;

   localparam int CH   = 2;
   localparam int SLOW = 8;
   localparam int FAST = 2;
   localparam int DEC  = 2;
   localparam int K    = 1;
   localparam int DZ   = 16;

   logic        CLK;
   logic        reset;
   logic        ce;
   logic [1:0]  mode;
   logic [1:0]  left;
   logic [1:0]  right;
   logic [15:0] axis;
   logic [3:0]  steer;
   logic [1:0]  active;
   logic [1:0]  step;

   int testsRun = 0;
   int failures = 0;

   // Model state: running flag, latched direction/mode, current interval,
   // ticks left until the next step, phase index 0..3 and this tick's step.
   int mRun[CH];
   int mDir[CH];
   int mMode[CH];
   int mInterval[CH];
   int mRemain[CH];
   int mPh[CH];
   int mStep[CH];

   typedef struct {
      logic       rst;
      logic [1:0] md;
      logic [1:0] l;
      logic [1:0] r;
      logic [15:0] ax;
      int         n;
      logic [1:0] eSteer0;
      logic       eAct0;
      logic       eStep0;
      int         eSteps0;
   } vec_t;

   vec_t vecs[$];

   steer_quad_multi #(
      .CHANNELS   (CH),
      .PERIOD_W   (16),
      .CLKDIV_SLOW(SLOW),
      .CLKDIV_FAST(FAST),
      .ACCEL_DEC  (DEC),
      .STEP_K     (K),
      .DEADZONE   (DZ)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .ce    (ce),
      .mode  (mode),
      .left  (left),
      .right (right),
      .axis  (axis),
      .steer (steer),
      .active(active),
      .step  (step)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [1:0] phaseCode(int idx);
      logic [1:0] code;
      case (idx)
         0:       code = 2'b00;
         1:       code = 2'b01;
         2:       code = 2'b11;
         default: code = 2'b10;
      endcase
      return code;
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   function automatic void modelTick();
      for (int c = 0; c < CH; c++) begin
         int ax;
         int m;
         int rq;
         int dr;
         int entry;
         int nxt;
         mStep[c] = 0;
         if (reset) begin
            mRun[c] = 0;
            mPh[c] = 0;
            mInterval[c] = SLOW;
            mRemain[c] = 0;
            continue;
         end
         if (!ce) continue;
         ax = $signed(axis[8*c +: 8]);
         m = (ax < 0) ? -ax : ax;
         if (m > 127) m = 127;
         if (mode[c]) begin
            rq = (m >= DZ) ? 1 : 0;
            dr = (ax > 0) ? 1 : 0;
            entry = FAST + (127 - m) * K;
         end else begin
            rq = (left[c] != right[c]) ? 1 : 0;
            dr = right[c] ? 1 : 0;
            entry = SLOW;
         end
         if (rq == 0) begin
            mRun[c] = 0;
         end else if (mRun[c] == 0 || dr != mDir[c] || int'(mode[c]) != mMode[c]) begin
            mRun[c] = 1;
            mDir[c] = dr;
            mMode[c] = int'(mode[c]);
            mInterval[c] = entry;
            mRemain[c] = entry;
         end else begin
            mRemain[c] = mRemain[c] - 1;
            if (mRemain[c] == 0) begin
               mPh[c] = (mPh[c] + (mDir[c] ? 1 : 3)) % 4;
               mStep[c] = 1;
               if (mode[c]) nxt = entry;
               else nxt = (mInterval[c] - DEC < FAST) ? FAST : mInterval[c] - DEC;
               mInterval[c] = nxt;
               mRemain[c] = nxt;
            end
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      logic [3:0] eSteer;
      logic [1:0] eAct;
      logic [1:0] eStep;
      eSteer = '0;
      eAct = '0;
      eStep = '0;
      for (int c = 0; c < CH; c++) begin
         eSteer[2*c +: 2] = phaseCode(mPh[c]);
         eAct[c] = (mRun[c] != 0);
         eStep[c] = (mStep[c] != 0);
      end
      check("model_steer", 32'(steer), 32'(eSteer));
      check("model_active", 32'(active), 32'(eAct));
      check("model_step", 32'(step), 32'(eStep));
   endtask

   task automatic applyStimulus(input logic rst, input logic ceV, input logic [1:0] md,
                                input logic [1:0] l, input logic [1:0] r, input logic [15:0] ax);
      reset = rst;
      ce = ceV;
      mode = md;
      left = l;
      right = r;
      axis = ax;
   endtask

   task automatic tick();
      @(posedge CLK);
      modelTick();
      @(negedge CLK);
      checkOutput();
   endtask

   function automatic void addVec(logic rst, logic [1:0] md, logic [1:0] l, logic [1:0] r,
                                  logic [15:0] ax, int n, logic [1:0] eS, logic eA,
                                  logic eP, int eN);
      vecs.push_back('{rst, md, l, r, ax, n, eS, eA, eP, eN});
   endfunction

   initial begin
      int stepCnt;
      int firstStep;
      int secondStep;
      int seen;
      logic [7:0] picks[8];

      applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);

      // Channel 0 directed sequence: digital ramp, both-pressed, reversal, analog.
      addVec(1, 2'b00, 2'b00, 2'b00, 16'h0000,  2, 2'b00, 0, 0, 0);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  1, 2'b00, 1, 0, 0);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  8, 2'b01, 1, 1, 1);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  6, 2'b11, 1, 1, 1);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  4, 2'b10, 1, 1, 1);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  2, 2'b00, 1, 1, 1);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  2, 2'b01, 1, 1, 1);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  2, 2'b11, 1, 1, 1);
      addVec(0, 2'b00, 2'b01, 2'b01, 16'h0000,  3, 2'b11, 0, 0, 0);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  1, 2'b11, 1, 0, 0);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  7, 2'b11, 1, 0, 0);
      addVec(0, 2'b00, 2'b00, 2'b01, 16'h0000,  1, 2'b10, 1, 1, 1);
      addVec(0, 2'b00, 2'b01, 2'b00, 16'h0000,  1, 2'b10, 1, 0, 0);
      addVec(0, 2'b00, 2'b01, 2'b00, 16'h0000,  8, 2'b11, 1, 1, 1);
      addVec(0, 2'b00, 2'b01, 2'b00, 16'h0000,  6, 2'b01, 1, 1, 1);
      addVec(0, 2'b00, 2'b01, 2'b00, 16'h0000,  4, 2'b00, 1, 1, 1);
      addVec(0, 2'b00, 2'b00, 2'b00, 16'h0000,  2, 2'b00, 0, 0, 0);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h007F,  1, 2'b00, 1, 0, 0);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h007F,  2, 2'b01, 1, 1, 1);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h007F,  2, 2'b11, 1, 1, 1);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h000F,  1, 2'b11, 0, 0, 0);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h0080,  1, 2'b11, 1, 0, 0);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h0080,  2, 2'b01, 1, 1, 1);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h0080,  2, 2'b00, 1, 1, 1);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h0080,  2, 2'b10, 1, 1, 1);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h0080,  2, 2'b11, 1, 1, 1);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h0040,  1, 2'b11, 1, 0, 0);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h0040, 64, 2'b11, 1, 0, 0);
      addVec(0, 2'b01, 2'b00, 2'b00, 16'h0040,  1, 2'b10, 1, 1, 1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, 1'b1, vecs[i].md, vecs[i].l, vecs[i].r, vecs[i].ax);
         stepCnt = 0;
         for (int k = 0; k < vecs[i].n; k++) begin
            tick();
            if (step[0]) stepCnt++;
         end
         check($sformatf("vec%0d_steer0", i), 32'(steer[1:0]), 32'(vecs[i].eSteer0));
         check($sformatf("vec%0d_active0", i), 32'(active[0]), 32'(vecs[i].eAct0));
         check($sformatf("vec%0d_step0", i), 32'(step[0]), 32'(vecs[i].eStep0));
         check($sformatf("vec%0d_stepcount0", i), 32'(stepCnt), 32'(vecs[i].eSteps0));
      end

      // ce low freezes a running channel; reset with ce low still clears it.
      applyStimulus(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 16'h0040);
      stepCnt = 0;
      for (int k = 0; k < 70; k++) begin
         tick();
         if (step[0]) stepCnt++;
      end
      check("freeze_steps", 32'(stepCnt), 32'd0);
      check("freeze_steer0", 32'(steer[1:0]), 32'(2'b10));
      check("freeze_active0", 32'(active[0]), 32'd1);
      applyStimulus(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 16'h0040);
      tick();
      check("reset_ce0_steer", 32'(steer), 32'd0);
      check("reset_ce0_active", 32'(active), 32'd0);

      // ce every 4th cycle: ch0 digital ramp stretched x4 while ch1 churns in analog.
      firstStep = -1;
      secondStep = -1;
      seen = 0;
      for (int cyc = 0; cyc < 120; cyc++) begin
         applyStimulus(1'b0, (cyc % 4) == 0, 2'b10, 2'b00, 2'b01,
                       {8'($urandom_range(0, 255)), 8'h00});
         tick();
         if (step[0]) begin
            if (seen == 0) firstStep = cyc;
            else if (seen == 1) secondStep = cyc;
            seen++;
         end
      end
      check("ce4_first_step_cycle", 32'(firstStep), 32'd32);
      check("ce4_second_step_cycle", 32'(secondStep), 32'd56);

      // Randomized traffic on both channels.
      picks[0] = 8'h80; picks[1] = 8'h7F; picks[2] = 8'h0F; picks[3] = 8'h10;
      picks[4] = 8'hF0; picks[5] = 8'hEF; picks[6] = 8'h00; picks[7] = 8'h40;
      applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);
      tick();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [1:0] md;
         logic [1:0] l;
         logic [1:0] r;
         logic [15:0] ax;
         md = mode;
         l = left;
         r = right;
         ax = axis;
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 15) == 0) md[c] = ~md[c];
            if ($urandom_range(0, 7) == 0) begin
               l[c] = 1'($urandom_range(0, 1));
               r[c] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) begin
               if ($urandom_range(0, 1) == 0) ax[8*c +: 8] = 8'($urandom_range(0, 255));
               else ax[8*c +: 8] = picks[$urandom_range(0, 7)];
            end
         end
         applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, md, l, r, ax);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
